// File: rtl/ofs_fim_pcie_ss_tx_arb_pkg.sv
// PCIe SS TX arbiter: shared types and default widths.
// FSM state enum plus default parameter values for the slice.
package ofs_fim_pcie_ss_tx_arb_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DATA_W    = 512;
  localparam int DEF_USER_W    = 10;
  localparam int DEF_WEIGHT_W  = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

endpackage

// File: rtl/ofs_fim_pcie_ss_tx_arb_if.sv
// PCIe SS TX arbiter: per-port AXI-S sources and merged sink.
// master drives the sources / sinks the output; slave is the arbiter.
interface ofs_fim_pcie_ss_tx_arb_if
  import ofs_fim_pcie_ss_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int USER_W    = DEF_USER_W
);

  logic [NUM_PORTS-1:0]                 in_tvalid;
  logic [NUM_PORTS-1:0]                 in_tready;
  logic [NUM_PORTS-1:0]                 in_tlast;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     in_tdata;
  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   in_tkeep;
  logic [NUM_PORTS-1:0][USER_W-1:0]     in_tuser;

  logic                out_tvalid;
  logic                out_tready;
  logic                out_tlast;
  logic [DATA_W-1:0]   out_tdata;
  logic [DATA_W/8-1:0] out_tkeep;
  logic [USER_W-1:0]   out_tuser;

  modport master (
    output in_tvalid, in_tlast, in_tdata,
    output in_tkeep, in_tuser, out_tready,
    input  in_tready, out_tvalid, out_tlast,
    input  out_tdata, out_tkeep, out_tuser
  );

  modport slave (
    input  in_tvalid, in_tlast, in_tdata,
    input  in_tkeep, in_tuser, out_tready,
    output in_tready, out_tvalid, out_tlast,
    output out_tdata, out_tkeep, out_tuser
  );

endinterface

// File: rtl/ofs_fim_pcie_ss_tx_arb_pick.sv
// PCIe SS TX arbiter: rotating-priority picker.
// Finds the first valid port at or after rr_ptr, wrapping.
module ofs_fim_pcie_ss_tx_arb_pick
  import ofs_fim_pcie_ss_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] j;

  // scan from furthest to nearest so the nearest valid port wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (valid[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/ofs_fim_pcie_ss_tx_arb.sv
// PCIe SS TX arbiter: weighted round-robin packet merge.
// Define OFS_FIM_PCIE_SS_TX_ARB_STATS_EN for per-port packet counters.
module ofs_fim_pcie_ss_tx_arb
  import ofs_fim_pcie_ss_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int USER_W    = DEF_USER_W,
  parameter int WEIGHT_W  = DEF_WEIGHT_W,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic clk,
  input  logic rst,
  ofs_fim_pcie_ss_tx_arb_if.slave tx,
  input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0] cfg_weight,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][31:0] stat_pkt_cnt
`endif
);

  function automatic logic [WEIGHT_W-1:0] eff_wt(
    input logic [WEIGHT_W-1:0] w
  );
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  t_arb_state state;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] nxt;
  logic             pick_found;
  logic             sel_en;
  logic             can_take;
  logic             accept;
  logic             done;
  logic             cred_vld;
  logic [WEIGHT_W-1:0] base;
  logic [WEIGHT_W-1:0] rem;
  logic [NUM_PORTS-1:0][WEIGHT_W-1:0] credit;

  ofs_fim_pcie_ss_tx_arb_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .valid  (tx.in_tvalid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // port select, accept qualification and credit arithmetic
  always_comb begin
    sel      = (state == ARB_LOCKED) ? grant_idx : pick_idx;
    sel_en   = (state == ARB_LOCKED) | pick_found;
    can_take = tx.out_tready | ~tx.out_tvalid;
    accept   = ~rst & sel_en & can_take & tx.in_tvalid[sel];
    done     = accept & tx.in_tlast[sel];
    base     = (cred_vld && sel == rr_ptr) ? credit[sel]
                                           : eff_wt(cfg_weight[sel]);
    rem      = base - WEIGHT_W'(1);
    nxt      = (sel == IDX_W'(NUM_PORTS - 1)) ? '0
                                              : sel + IDX_W'(1);
  end

  // ready only toward the selected port while the output can take a beat
  always_comb begin
    tx.in_tready = '0;
    if (~rst & sel_en & can_take)
      tx.in_tready[sel] = 1'b1;
  end

  // packet lock FSM: hold grant until the tlast beat is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      busy      <= 1'b0;
      grant_idx <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (accept && !tx.in_tlast[sel]) begin
            state     <= ARB_LOCKED;
            busy      <= 1'b1;
            grant_idx <= sel;
          end
        end
        ARB_LOCKED: begin
          if (done) begin
            state <= ARB_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // weighted round-robin pointer; a skipped owner gets a fresh turn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      cred_vld <= 1'b0;
      credit   <= '0;
    end else if (done) begin
      cred_vld <= 1'b1;
      if (sel != rr_ptr)
        credit[rr_ptr] <= eff_wt(cfg_weight[rr_ptr]);
      if (rem != '0) begin
        rr_ptr      <= sel;
        credit[sel] <= rem;
      end else begin
        rr_ptr      <= nxt;
        credit[nxt] <= eff_wt(cfg_weight[nxt]);
      end
    end
  end

  // one-deep output register valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tx.out_tvalid <= 1'b0;
    else if (accept)
      tx.out_tvalid <= 1'b1;
    else if (tx.out_tready)
      tx.out_tvalid <= 1'b0;
  end

  // output payload; left unreset since out_tvalid qualifies it
  always_ff @(posedge clk) begin
    if (accept) begin
      tx.out_tdata <= tx.in_tdata[sel];
      tx.out_tkeep <= tx.in_tkeep[sel];
      tx.out_tuser <= tx.in_tuser[sel];
      tx.out_tlast <= tx.in_tlast[sel];
    end
  end

`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
  // saturating completed-packet counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stat_pkt_cnt <= '0;
    else if (done && stat_pkt_cnt[sel] != '1)
      stat_pkt_cnt[sel] <= stat_pkt_cnt[sel] + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_arb.sv
// Directed bench for the PCIe SS TX arbiter.
// Port id rides in tdata[31:24] and tuser; beat number in tdata[23:0].
module tb_ofs_fim_pcie_ss_tx_arb;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int UW = 10;
  localparam int WW = 4;

  logic clk;
  logic rst;
  logic [NP-1:0][WW-1:0] cfg_weight;
  logic [1:0] grant_idx;
  logic       busy;
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
  logic [NP-1:0][31:0] stat_pkt_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  ofs_fim_pcie_ss_tx_arb_if #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .USER_W    (UW)
  ) bus ();

  ofs_fim_pcie_ss_tx_arb #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .USER_W    (UW),
    .WEIGHT_W  (WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (bus),
    .cfg_weight (cfg_weight),
    .grant_idx  (grant_idx),
    .busy       (busy)
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
    ,
    .stat_pkt_cnt (stat_pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.in_tvalid = '0;
    bus.in_tlast  = '0;
  endtask

  task automatic put(input int p, input int seq, input bit last);
    bus.in_tvalid[p] = 1'b1;
    bus.in_tlast[p]  = last;
    bus.in_tdata[p]  = {8'(p), 24'(seq)};
    bus.in_tkeep[p]  = '1;
    bus.in_tuser[p]  = UW'(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    bus.out_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] dw(input int p, input int seq);
    return {8'(p), 24'(seq)};
  endfunction

  initial begin
    rst            = 1'b1;
    bus.in_tdata   = '0;
    bus.in_tkeep   = '0;
    bus.in_tuser   = '0;
    bus.out_tready = 1'b1;
    cfg_weight     = {4'd1, 4'd1, 4'd1, 4'd1};
    idle_in();
    for (int p = 0; p < NP; p++) put(p, 0, 1'b1);

    // reset state, with every source offering a beat
    #1;
    check("rst_rdy",   bus.in_tready,  4'b0000);
    check("rst_ovld",  bus.out_tvalid, 1'b0);
    check("rst_busy",  busy,           1'b0);
    check("rst_grant", grant_idx,      2'd0);
    repeat (2) @(negedge clk);
    check("rst_ovld2", bus.out_tvalid, 1'b0);

    // equal weights, all ports streaming single-beat packets
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rr_port", bus.out_tdata[31:24], k % 4);
      check("rr_user", bus.out_tuser,        k % 4);
      check("rr_vld",  bus.out_tvalid,       1'b1);
      check("rr_busy", busy,                 1'b0);
    end

    // weights {3,1,0,0}, ports 0 and 1 always valid
    cfg_weight = {4'd0, 4'd0, 4'd1, 4'd3};
    do_reset();
    put(0, 0, 1'b1);
    put(1, 0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("wt_port", bus.out_tdata[31:24],
            (k % 4 == 3) ? 1 : 0);
    end

    // port 2 five-beat packet, port 0 contending mid-packet
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_in();
      put(2, i, i == 4);
      if (i >= 1 && i <= 3) put(0, 99, 1'b1);
      #1;
      check("lk_rdy", bus.in_tready, 4'b0100);
      @(negedge clk);
      check("lk_beat", bus.out_tdata, dw(2, i));
      check("lk_busy", busy, i < 4);
      if (i < 4) check("lk_grant", grant_idx, 2'd2);
    end
    idle_in();
    put(0, 7, 1'b1);
    #1;
    check("lk_rdy0", bus.in_tready, 4'b0001);
    @(negedge clk);
    check("lk_p0", bus.out_tdata, dw(0, 7));
    check("lk_busy0", busy, 1'b0);
    idle_in();
    @(negedge clk);
    check("lk_drain", bus.out_tvalid, 1'b0);

    // output backpressure then input stall inside a port-1 packet
    do_reset();
    for (int i = 0; i < 2; i++) begin
      put(1, i, 1'b0);
      @(negedge clk);
      check("bp_beat", bus.out_tdata, dw(1, i));
    end
    bus.out_tready = 1'b0;
    put(1, 2, 1'b0);
    put(0, 50, 1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_rdy", bus.in_tready, 4'b0000);
      @(negedge clk);
      check("bp_hold", bus.out_tdata, dw(1, 1));
      check("bp_vld", bus.out_tvalid, 1'b1);
    end
    bus.out_tready = 1'b1;
    #1;
    check("bp_rdy1", bus.in_tready, 4'b0010);
    @(negedge clk);
    check("bp_b2", bus.out_tdata, dw(1, 2));
    put(1, 3, 1'b0);
    @(negedge clk);
    check("bp_b3", bus.out_tdata, dw(1, 3));
    bus.in_tvalid[1] = 1'b0;
    #1;
    check("st_rdy", bus.in_tready, 4'b0010);
    @(negedge clk);
    check("st_vld", bus.out_tvalid, 1'b0);
    check("st_busy", busy, 1'b1);
    put(1, 4, 1'b0);
    @(negedge clk);
    check("st_b4", bus.out_tdata, dw(1, 4));
    put(1, 5, 1'b1);
    @(negedge clk);
    check("st_b5", bus.out_tdata, dw(1, 5));
    check("st_last", bus.out_tlast, 1'b1);
    check("st_busy0", busy, 1'b0);
    bus.in_tvalid[1] = 1'b0;
    @(negedge clk);
    check("st_p0", bus.out_tdata, dw(0, 50));

    // reset on beat 3 of a port-3 packet
    do_reset();
    for (int i = 0; i < 2; i++) begin
      put(3, i, 1'b0);
      @(negedge clk);
      check("mr_beat", bus.out_tdata, dw(3, i));
    end
    put(3, 2, 1'b0);
    rst = 1'b1;
    #1;
    check("mr_vld", bus.out_tvalid, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_rdy", bus.in_tready, 4'b0000);
    @(negedge clk);
    check("mr_vld2", bus.out_tvalid, 1'b0);
    check("mr_grant", grant_idx, 2'd0);
    rst = 1'b0;
    idle_in();
    put(0, 85, 1'b1);
    #1;
    check("mr_rdy0", bus.in_tready, 4'b0001);
    @(negedge clk);
    check("mr_out", bus.out_tdata, dw(0, 85));
    check("mr_ovld", bus.out_tvalid, 1'b1);
    idle_in();
    @(negedge clk);
    check("mr_drain", bus.out_tvalid, 1'b0);

`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
    // 300 single-beat packets on port 1
    do_reset();
    put(1, 0, 1'b1);
    repeat (300) @(negedge clk);
    idle_in();
    @(negedge clk);
    check("st_cnt0", stat_pkt_cnt[0], 32'd0);
    check("st_cnt1", stat_pkt_cnt[1], 32'd300);
    check("st_cnt2", stat_pkt_cnt[2], 32'd0);
    check("st_cnt3", stat_pkt_cnt[3], 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
